// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned ADD3_THRESH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OP   = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // 10**n, evaluated at elaboration to check that the digit count covers the input range
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// start/done_tick handshake plus data bus between the converter and its neighbours.
interface bin2bcd_seq_if
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
);

  logic                          start;
  logic [W-1:0]                  bin;
  logic                          ready;
  logic                          done_tick;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;

  modport master (
    output start,
    output bin,
    input  ready,
    input  done_tick,
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output ready,
    output done_tick,
    output bcd
  );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Single BCD digit correction used before each double-dabble shift.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_d,
  output logic [BCD_DIGIT_W-1:0] o_d
);

  // Add 3 to any digit above 4 so the following shift carries correctly into the next digit
  always_comb begin
    o_d = i_d;
    if (i_d > BCD_DIGIT_W'(ADD3_THRESH)) begin
      o_d = i_d + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per op cycle.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
)
(
  input  logic           clk,
  input  logic           reset,
  bin2bcd_seq_if.slave   bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(W + 1);

  // Reject configurations that cannot represent the full input range
  if (W == 0) begin : g_bad_w
    $error("bin2bcd_seq: W must be at least 1");
  end
  if (pow10(DIGITS) <= ((64'd1 << W) - 64'd1)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for W");
  end

  state_t             r_state;
  logic [W-1:0]       r_bin;
  logic [BCD_W-1:0]   r_dig;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_done;

  state_t             w_state_nxt;
  logic [W-1:0]       w_bin_nxt;
  logic [BCD_W-1:0]   w_dig_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic               w_done_nxt;
  logic [BCD_W-1:0]   w_adj;

  // Per-digit add-3 correction of the current digit register
  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .i_d (r_dig[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .o_d (w_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
    );
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_dig   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_dig   <= w_dig_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcd   <= w_bcd_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and datapath; the result and done pulse are registered on entry to done
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_dig_nxt   = r_dig;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_bin_nxt   = bus.bin;
          w_dig_nxt   = '0;
          w_cnt_nxt   = CNT_W'(W);
          w_state_nxt = ST_OP;
        end
      end
      ST_OP: begin
        {w_dig_nxt, w_bin_nxt} = {w_adj, r_bin} << 1;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_bcd_nxt   = w_dig_nxt;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.ready     = (r_state == ST_IDLE);
  assign bus.done_tick = r_done;
  assign bus.bcd       = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
module tb_bin2bcd_seq;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  bin2bcd_seq_if #(.W(8), .DIGITS(3)) bus ();

  bin2bcd_seq #(.W(8), .DIGITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One conversion from idle: returns negedges from the start edge to done_tick, and bcd then
  task automatic run_conv(input logic [7:0] v, output int lat, output logic [11:0] res);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = v;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (bus.done_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    res = bus.bcd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.bin = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready);
    end
    checks++;
    if (bus.done_tick !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b exp=0", bus.done_tick);
    end
    checks++;
    if (bus.bcd !== 12'h000) begin
      errors++; $display("FAIL reset_bcd got=%h exp=000", bus.bcd);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  vin [4];
    logic [11:0] vexp [4];
    int lat;
    logic [11:0] res;
    vin  = '{8'd0, 8'd255, 8'd99, 8'd100};
    vexp = '{12'h000, 12'h255, 12'h099, 12'h100};
    for (int i = 0; i < 4; i++) begin
      run_conv(vin[i], lat, res);
      checks++;
      if (lat !== 9) begin
        errors++; $display("FAIL basic_latency bin=%0d got=%0d exp=9", vin[i], lat);
      end
      checks++;
      if (res !== vexp[i]) begin
        errors++; $display("FAIL basic_bcd bin=%0d got=%h exp=%h", vin[i], res, vexp[i]);
      end
      checks++;
      if (bus.ready !== 1'b1 || bus.done_tick !== 1'b0) begin
        errors++; $display("FAIL basic_after ready=%b done=%b exp ready=1 done=0", bus.ready, bus.done_tick);
      end
    end
  endtask

  task automatic test_exhaustive();
    int lat;
    logic [11:0] res;
    logic [11:0] exp;
    string s;
    for (int v = 0; v < 256; v++) begin
      s = $sformatf("%03d", v);
      exp = {4'(s[0] - 8'd48), 4'(s[1] - 8'd48), 4'(s[2] - 8'd48)};
      run_conv(8'(v), lat, res);
      checks++;
      if (res !== exp || lat !== 9) begin
        errors++; $display("FAIL exhaustive bin=%0d got=%h lat=%0d exp=%h lat=9", v, res, lat, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ticks;
    logic [11:0] res;
    logic rdy_op;
    ticks = 0;
    res = 12'hfff;
    rdy_op = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin = 8'd42;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (bus.done_tick === 1'b1) begin
        ticks++;
        res = bus.bcd;
      end
      if (c == 1) bus.start = 1'b0;
      if (c == 3) begin
        rdy_op = bus.ready;
        bus.start = 1'b1;
        bus.bin = 8'd7;
      end
      if (c == 4) bus.start = 1'b0;
    end
    checks++;
    if (rdy_op !== 1'b0) begin
      errors++; $display("FAIL ignore_ready_in_op got=%b exp=0", rdy_op);
    end
    checks++;
    if (ticks !== 1) begin
      errors++; $display("FAIL ignore_ticks got=%0d exp=1", ticks);
    end
    checks++;
    if (res !== 12'h042) begin
      errors++; $display("FAIL ignore_bcd got=%h exp=042", res);
    end
  endtask

  task automatic test_reset_midop();
    int ticks;
    int lat;
    logic [11:0] res;
    ticks = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.ready !== 1'b1 || bus.done_tick !== 1'b0 || bus.bcd !== 12'h000) begin
      errors++; $display("FAIL midop_reset ready=%b done=%b bcd=%h exp ready=1 done=0 bcd=000",
                         bus.ready, bus.done_tick, bus.bcd);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 0) begin
      errors++; $display("FAIL midop_no_tick got=%0d exp=0", ticks);
    end
    run_conv(8'd13, lat, res);
    checks++;
    if (res !== 12'h013 || lat !== 9) begin
      errors++; $display("FAIL midop_next got=%h lat=%0d exp=013 lat=9", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int unstable;
    logic [11:0] r1;
    logic [11:0] r2;
    t1 = -1;
    t2 = -1;
    unstable = 0;
    r1 = 12'hfff;
    r2 = 12'hfff;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin = 8'd5;
    for (int c = 1; c <= 40 && t2 < 0; c++) begin
      @(negedge clk);
      if (bus.done_tick === 1'b1) begin
        if (t1 < 0) begin
          t1 = c; r1 = bus.bcd; bus.bin = 8'd6;
        end else begin
          t2 = c; r2 = bus.bcd; bus.start = 1'b0;
        end
      end else if (t1 >= 0 && bus.bcd !== 12'h005) begin
        unstable++;
      end
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (t1 !== 9) begin
      errors++; $display("FAIL b2b_first_latency got=%0d exp=9", t1);
    end
    checks++;
    if (t2 - t1 !== 10) begin
      errors++; $display("FAIL b2b_interval got=%0d exp=10", t2 - t1);
    end
    checks++;
    if (r1 !== 12'h005 || r2 !== 12'h006) begin
      errors++; $display("FAIL b2b_results got=%h,%h exp=005,006", r1, r2);
    end
    checks++;
    if (unstable !== 0) begin
      errors++; $display("FAIL b2b_stable got=%0d exp=0", unstable);
    end
  endtask

  // Upstream stand-in: 4-bit f values, zero-extended onto bin, done_tick pulses as start
  task automatic test_chain();
    logic [3:0]  f_tab [5];
    logic [11:0] exp_tab [5];
    int lat;
    logic [11:0] res;
    f_tab   = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12};
    exp_tab = '{12'h000, 12'h003, 12'h006, 12'h009, 12'h012};
    for (int i = 0; i < 5; i++) begin
      repeat (2) @(negedge clk);
      run_conv({4'b0, f_tab[i]}, lat, res);
      checks++;
      if (res !== exp_tab[i] || lat !== 9) begin
        errors++; $display("FAIL chain i=%0d got=%h lat=%0d exp=%h lat=9", i, res, lat, exp_tab[i]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.bin = 8'd0;
    test_reset();
    test_basic();
    test_exhaustive();
    test_ignore_start();
    test_reset_midop();
    test_back_to_back();
    test_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
